// File: rtl/gpu_pkg.sv
// Shared GPU definitions: op-select encodings, default geometry and the
// rectangle-fill state type.
package gpu_pkg;

    localparam logic [3:0] OP_CF   = 4'd0;
    localparam logic [3:0] OP_CD   = 4'd1;
    localparam logic [3:0] OP_RF   = 4'd2;
    localparam logic [3:0] OP_RD   = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_FU   = 4'd10;
    localparam logic [3:0] OP_IDLE = 4'd15;

    localparam int DEF_H_RES = 320;
    localparam int DEF_V_RES = 240;
    localparam int DEF_X_W   = 9;
    localparam int DEF_Y_W   = 8;

    typedef enum logic [1:0] {
        RF_IDLE   = 2'd0,
        RF_SETUP  = 2'd1,
        RF_SCAN   = 2'd2,
        RF_FINISH = 2'd3
    } rf_state_t;

endpackage

// File: rtl/coord_sort.sv
// Combinational unsigned min/max of two coordinates.
module coord_sort #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_min,
    output logic [W-1:0] o_max
);

    logic w_a_lt_b;

    assign w_a_lt_b = (i_a < i_b);
    assign o_min    = w_a_lt_b ? i_a : i_b;
    assign o_max    = w_a_lt_b ? i_b : i_a;

endmodule

// File: rtl/rect_fill_gen.sv
// Rectangle-fill coordinate generator: streams every pixel of a normalised
// rectangle in raster order. Optional clipping to H_RES x V_RES via RECT_CLIP_EN.
module rect_fill_gen
    import gpu_pkg::*;
#(
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W,
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [X_W-1:0] X0,
    input  logic [X_W-1:0] X1,
    input  logic [Y_W-1:0] Y0,
    input  logic [Y_W-1:0] Y1,
    input  logic           PIX_READY,
    output logic           PIX_VALID,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           BUSY,
    output logic           DONE,
    output rf_state_t      o_dbg_state
);

    localparam logic [X_W-1:0] X_LIM = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(V_RES - 1);
    localparam logic [X_W:0]   X_RES = (X_W + 1)'(H_RES);
    localparam logic [Y_W:0]   Y_RES = (Y_W + 1)'(V_RES);

    rf_state_t      r_state;
    logic [X_W-1:0] r_x0, r_x1, r_xmin, r_xmax, r_cur_x;
    logic [Y_W-1:0] r_y0, r_y1, r_ymax, r_cur_y;
    logic           r_valid, r_busy, r_done;

    logic [X_W-1:0] w_xmin, w_xmax, w_xmax_c;
    logic [Y_W-1:0] w_ymin, w_ymax, w_ymax_c;
    logic           w_clip_en, w_empty, w_hs;

`ifdef RECT_CLIP_EN
    assign w_clip_en = 1'b1;
`else
    assign w_clip_en = 1'b0;
`endif

    coord_sort #(.W(X_W)) u_sort_x (
        .i_a   (r_x0),
        .i_b   (r_x1),
        .o_min (w_xmin),
        .o_max (w_xmax)
    );

    coord_sort #(.W(Y_W)) u_sort_y (
        .i_a   (r_y0),
        .i_b   (r_y1),
        .o_min (w_ymin),
        .o_max (w_ymax)
    );

    // Clipping only lowers the max corner; a min corner past the screen edge empties the region.
    assign w_xmax_c = (w_clip_en && (w_xmax > X_LIM)) ? X_LIM : w_xmax;
    assign w_ymax_c = (w_clip_en && (w_ymax > Y_LIM)) ? Y_LIM : w_ymax;
    assign w_empty  = w_clip_en && (({1'b0, w_xmin} >= X_RES) || ({1'b0, w_ymin} >= Y_RES));

    // Handshake: a pixel transfers on a rising edge where PIX_VALID && PIX_READY; while
    // PIX_VALID is high and PIX_READY low, x_out/y_out stay stable until accepted.
    assign w_hs = r_valid && PIX_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RF_IDLE;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymax  <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_x0    <= X0;
                        r_x1    <= X1;
                        r_y0    <= Y0;
                        r_y1    <= Y1;
                        r_busy  <= 1'b1;
                        r_state <= RF_SETUP;
                    end
                end
                RF_SETUP: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= RF_FINISH;
                    end else begin
                        r_xmin  <= w_xmin;
                        r_xmax  <= w_xmax_c;
                        r_ymax  <= w_ymax_c;
                        r_cur_x <= w_xmin;
                        r_cur_y <= w_ymin;
                        r_valid <= 1'b1;
                        r_state <= RF_SCAN;
                    end
                end
                RF_SCAN: begin
                    if (w_hs) begin
                        if (r_cur_x != r_xmax) begin
                            r_cur_x <= r_cur_x + X_W'(1);
                        end else if (r_cur_y != r_ymax) begin
                            r_cur_x <= r_xmin;
                            r_cur_y <= r_cur_y + Y_W'(1);
                        end else begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= RF_FINISH;
                        end
                    end
                end
                RF_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= RF_IDLE;
                end
                default: r_state <= RF_IDLE;
            endcase
        end
    end

    assign PIX_VALID   = r_valid;
    assign x_out       = r_cur_x;
    assign y_out       = r_cur_y;
    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign o_dbg_state = r_state;

endmodule
